te_normalized_min_scaler: RTL and testbench
===========================================

// Module: te_normalized_min_scaler
// PURPOSE
//  Transmission-estimation stage that sits directly upstream of the T(x) subtractor.
//  Per pixel it computes w * min(Pc/Ac), c in {R,G,B}, as Q0.16 and feeds the subtractor's 16-bit input.
//  Structure: 4-stage pipeline with valid/ready on both sides.
//  Atmospheric-light reciprocals are loaded through a small FSM that drains the pipeline first.
// PARAMETERS
//  OMEGA   16'd62259  haze-retention factor w, Q0.16 (~0.95)
//  INV_W   17         width of 1/Ac reciprocal inputs, Q1.16 (65536 = 1.0)
// PORTS
//  clk         in   1      system clock, rising edge
//  rst         in   1      asynchronous, active-low reset
//  a_load      in   1      1-cycle pulse: capture inv_a_r/g/b
//  inv_a_r     in   17     1/Ar in Q1.16 (host supplies round(65536/Ar))
//  inv_a_g     in   17     1/Ag in Q1.16
//  inv_a_b     in   17     1/Ab in Q1.16
//  in_valid    in   1      pixel valid
//  in_ready    out  1      stage accepts pixel
//  in_r        in   8      pixel red
//  in_g        in   8      pixel green
//  in_b        in   8      pixel blue
//  out_valid   out  1      result valid
//  out_ready   in   1      downstream accepts result
//  out_data    out  16     w*min(Pc/Ac), Q0.16
//  busy_load   out  1      high while in WAIT_A or DRAIN
// BEHAVIOUR
//  Reset: FSM=WAIT_A; inv regs=0; all stage valids=0; out_valid=0; out_data=0; in_ready=0; busy_load=1.
//  Pipeline enable: en = !out_valid | out_ready. All stages advance together only when en=1.
//  Transfer: accepted when in_valid & in_ready; out beat completes when out_valid & out_ready.
//  S1: pr=in_r*inv_r, pg=in_g*inv_g, pb=in_b*inv_b (25-bit unsigned, Q8.16); valid captured.
//  S2: each product clamped to 16'hFFFF if >=65536, else low 16 bits; m = min of the three.
//    Ties: any equal value is taken.
//  S3: q = (m*OMEGA)>>16. Truncation, no rounding; 32-bit product; result always <= OMEGA.
//  S4: out_data <= q; out_valid <= S3 valid (gated by en).
//  Latency: 4 clk from accept to out_valid, with out_ready held high.
//  Throughput: 1 pixel/clk.
//  Stall: out_valid=1 & out_ready=0 freezes every stage; out_data stable, no loss, no duplication.
//  FSM states:
//   WAIT_A -- a_load captures inv regs and goes to RUN; in_ready=0.
//   RUN -- in_ready=en. On a_load: inv inputs held in shadow regs, go to DRAIN.
//   DRAIN -- in_ready=0. When S1..S3 valids and out_valid are all 0, copy shadow to inv regs and go to RUN.
//  a_load while in DRAIN: shadow overwritten; last value wins.
//  a_load while in WAIT_A: captured directly.
//  In-flight pixels always use the reciprocals they were accepted with.
//  inv=0 gives a channel product of 0, hence out_data=0. This is legal; the host must avoid it.
//  in_valid in WAIT_A/DRAIN: ignored; no accept.
//  Reset mid-stream: all in-flight data discarded; FSM back to WAIT_A (reload required).
//  busy_load = (state != RUN).
// TESTING
//  1. Reset, then a_load with inv=257 x3, then pixel (128,128,128), out_ready=1
//     -> out_data=31251 exactly 4 clk after accept.
//  2. inv=65536 x3, pixel (255,0,255)
//     -> min clamp path gives 0, out_data=0.
//     Then pixel (255,255,255) -> S2 clamps to 65535, out_data=62258.
//  3. inv=257 x3, pixel (200,100,50) -> min=12850, out_data=12207.
//     Repeat with the channels permuted -> same 12207.
//  4. Stream of 16 pixels; out_ready toggled 1,0,0,1 pattern
//     -> all 16 results in order, none dropped or duplicated.
//     out_data stable while stalled.
//  5. a_load (inv 257->514) mid-stream
//     -> in_ready=0 until the pipe empties, which takes 4 clk.
//     Earlier pixels use 257, later ones use 514.
//     Pixel (100,100,100) after reload -> 51400 -> out_data=48829.
//  6. Assert rst with 3 pixels in flight -> out_valid=0 immediately, state WAIT_A.
//     in_valid held high -> no accept until a_load.

Source files
------------

// File: rtl/te_normalized_min_scaler.sv
// te_normalized_min_scaler: computes w * min(Pc/Ac) per pixel as Q0.16 in a 4-stage valid/ready pipeline.
// Reloading the 1/Ac reciprocals drains the pipe first, so each pixel keeps the reciprocals it was accepted with.
module te_normalized_min_scaler #(
   parameter logic [15:0] OMEGA = 16'd62259,
   parameter int          INV_W = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_load_i,
   input  logic [INV_W-1:0] inv_a_r_i,
   input  logic [INV_W-1:0] inv_a_g_i,
   input  logic [INV_W-1:0] inv_a_b_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [7:0]       in_r_i,
   input  logic [7:0]       in_g_i,
   input  logic [7:0]       in_b_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [15:0]      out_data_o,
   output logic             busy_load_o
);

   localparam int PW = INV_W + 8;

   typedef enum logic [1:0] {
      WAIT_A = 2'd0,
      RUN    = 2'd1,
      DRAIN  = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic [INV_W-1:0] inv_r_q, inv_r_d;
   logic [INV_W-1:0] inv_g_q, inv_g_d;
   logic [INV_W-1:0] inv_b_q, inv_b_d;
   logic [INV_W-1:0] sh_r_q, sh_r_d;
   logic [INV_W-1:0] sh_g_q, sh_g_d;
   logic [INV_W-1:0] sh_b_q, sh_b_d;

   logic          v1_q, v2_q, v3_q, out_valid_q;
   logic [PW-1:0] pr_q, pg_q, pb_q;
   logic [PW-1:0] pr_d, pg_d, pb_d;
   logic [15:0]   m_q, m_d;
   logic [15:0]   q_q, q_d;
   logic [15:0]   out_data_q;

   logic          en;
   logic          accept;
   logic          pipe_empty;
   logic [15:0]   c_r, c_g, c_b;
   logic [31:0]   scaled;

   // One enable for every stage: the whole pipe moves or holds as a unit.
   assign en         = !out_valid_q || out_ready_i;
   assign accept     = in_valid_i && in_ready_o;
   assign pipe_empty = !v1_q && !v2_q && !v3_q && !out_valid_q;

   function automatic logic [15:0] clamp16(input logic [PW-1:0] p);
      return (p[PW-1:16] != '0) ? 16'hFFFF : p[15:0];
   endfunction

   // S1 products use the live reciprocal registers; they only change while the pipe is empty.
   assign pr_d = PW'(in_r_i) * PW'(inv_r_q);
   assign pg_d = PW'(in_g_i) * PW'(inv_g_q);
   assign pb_d = PW'(in_b_i) * PW'(inv_b_q);

   // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      c_r = clamp16(pr_q);
      c_g = clamp16(pg_q);
      c_b = clamp16(pb_q);
      m_d = c_r;
      if (c_g < m_d) m_d = c_g;
      if (c_b < m_d) m_d = c_b;
   end

   assign scaled = 32'(m_q) * 32'(OMEGA);
   assign q_d    = scaled[31:16];

   always_comb begin
      state_d    = state_q;
      inv_r_d    = inv_r_q;
      inv_g_d    = inv_g_q;
      inv_b_d    = inv_b_q;
      sh_r_d     = sh_r_q;
      sh_g_d     = sh_g_q;
      sh_b_d     = sh_b_q;
      in_ready_o = 1'b0;
      unique case (state_q)
         WAIT_A: begin
            if (a_load_i) begin
               inv_r_d = inv_a_r_i;
               inv_g_d = inv_a_g_i;
               inv_b_d = inv_a_b_i;
               state_d = RUN;
            end
         end
         RUN: begin
            in_ready_o = en;
            if (a_load_i) begin
               sh_r_d  = inv_a_r_i;
               sh_g_d  = inv_a_g_i;
               sh_b_d  = inv_a_b_i;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (a_load_i) begin
               sh_r_d = inv_a_r_i;
               sh_g_d = inv_a_g_i;
               sh_b_d = inv_a_b_i;
            end
            // A load arriving on the very cycle the pipe empties is the newest value and wins.
            if (pipe_empty) begin
               inv_r_d = a_load_i ? inv_a_r_i : sh_r_q;
               inv_g_d = a_load_i ? inv_a_g_i : sh_g_q;
               inv_b_d = a_load_i ? inv_a_b_i : sh_b_q;
               state_d = RUN;
            end
         end
         default: state_d = WAIT_A;
      endcase
   end

   // NOTE: sequential state is written with non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WAIT_A;
         inv_r_q <= '0;
         inv_g_q <= '0;
         inv_b_q <= '0;
         sh_r_q  <= '0;
         sh_g_q  <= '0;
         sh_b_q  <= '0;
      end else begin
         state_q <= state_d;
         inv_r_q <= inv_r_d;
         inv_g_q <= inv_g_d;
         inv_b_q <= inv_b_d;
         sh_r_q  <= sh_r_d;
         sh_g_q  <= sh_g_d;
         sh_b_q  <= sh_b_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         v3_q        <= 1'b0;
         out_valid_q <= 1'b0;
         pr_q        <= '0;
         pg_q        <= '0;
         pb_q        <= '0;
         m_q         <= '0;
         q_q         <= '0;
         out_data_q  <= '0;
      end else if (en) begin
         v1_q        <= accept;
         v2_q        <= v1_q;
         v3_q        <= v2_q;
         out_valid_q <= v3_q;
         if (accept) begin
            pr_q <= pr_d;
            pg_q <= pg_d;
            pb_q <= pb_d;
         end
         m_q        <= m_d;
         q_q        <= q_d;
         out_data_q <= q_q;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign busy_load_o = (state_q != RUN);

   stall_hold_a : assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid_q && !out_ready_i) |=> (out_valid_q && $stable(out_data_q)));

   no_accept_when_loading_a : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q != RUN) |-> !in_ready_o);

endmodule

// File: tb/tb_te_normalized_min_scaler.sv
// Directed bench for te_normalized_min_scaler: vector table plus stall, reload and reset sequences.
// Latency is counted in rising edges with the accepting edge as edge 1.
module tb_te_normalized_min_scaler;

   logic        clk;
   logic        rst_n;
   logic        a_load;
   logic [16:0] inv_r, inv_g, inv_b;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_r, in_g, in_b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        busy_load;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [7:0]  r, g, b;
      logic [16:0] ir, ig, ib;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[10];

   logic [7:0]  px_r[32], px_g[32], px_b[32];
   logic [15:0] px_exp[32];

   te_normalized_min_scaler dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .a_load_i    (a_load),
      .inv_a_r_i   (inv_r),
      .inv_a_g_i   (inv_g),
      .inv_a_b_i   (inv_b),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_r_i      (in_r),
      .in_g_i      (in_g),
      .in_b_i      (in_b),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .busy_load_o (busy_load)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Equal reciprocals on all channels: min of products equals product of the min pixel.
   function automatic logic [15:0] exp_uniform(input logic [7:0] r, g, b, input longint inv);
      longint mn, p;
      mn = r;
      if (g < mn) mn = g;
      if (b < mn) mn = b;
      p = mn * inv;
      if (p > 65535) p = 65535;
      return 16'((p * 62259) / 65536);
   endfunction

   task automatic load_inv(input logic [16:0] r, g, b);
      int guard;
      @(negedge clk);
      a_load = 1'b1;
      inv_r = r; inv_g = g; inv_b = b;
      @(negedge clk);
      a_load = 1'b0;
      #1;
      guard = 0;
      while (busy_load && guard < 20) begin
         @(negedge clk); #1;
         guard++;
      end
      check("load done", busy_load, 0);
   endtask

   task automatic run_one(input logic [7:0] r, g, b, input logic [15:0] exp, input string nm);
      int guard;
      int lat;
      @(negedge clk);
      in_valid = 1'b1;
      in_r = r; in_g = g; in_b = b;
      #1;
      guard = 0;
      while (!in_ready && guard < 20) begin
         @(negedge clk); #1;
         guard++;
      end
      check({nm, " accept"}, in_ready, 1);
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      while (!out_valid && lat < 20) begin
         @(negedge clk); #1;
         lat++;
      end
      check({nm, " latency"}, lat, 4);
      check({nm, " data"}, out_data, exp);
   endtask

   task automatic run_stream(input int n, input bit toggle, input int load_at, input logic [16:0] new_inv);
      int idx_in, idx_out, cyc, low_cnt;
      bit prev_stall, load_done, draining, fire, acc, pop;
      logic [15:0] prev_data;
      idx_in = 0; idx_out = 0; cyc = 0; low_cnt = 0;
      prev_stall = 0; load_done = 0; draining = 0;
      prev_data = '0;
      while (idx_out < n && cyc < 500) begin
         @(negedge clk);
         out_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         a_load = 1'b0;
         fire = 0;
         if (load_at >= 0 && !load_done && idx_in == load_at) begin
            a_load = 1'b1;
            inv_r = new_inv; inv_g = new_inv; inv_b = new_inv;
            load_done = 1; draining = 1; fire = 1; low_cnt = 0;
         end
         in_valid = (idx_in < n);
         if (idx_in < n) begin
            in_r = px_r[idx_in]; in_g = px_g[idx_in]; in_b = px_b[idx_in];
         end
         #1;
         if (prev_stall) begin
            check("stall valid held", out_valid, 1);
            check("stall data held", out_data, prev_data);
         end
         if (draining && !fire) begin
            if (!in_ready) low_cnt++;
            else begin
               draining = 0;
               check("drain length in range", (low_cnt >= 4 && low_cnt <= 6), 1);
               check("pipe empty on resume", out_valid, 0);
            end
         end
         acc = in_valid && in_ready;
         pop = out_valid && out_ready;
         if (pop) check("stream data", out_data, px_exp[idx_out]);
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         if (acc) idx_in++;
         if (pop) idx_out++;
         cyc++;
      end
      check("stream count", idx_out, n);
      in_valid = 1'b0;
      out_ready = 1'b1;
      a_load = 1'b0;
      repeat (3) begin
         @(negedge clk); #1;
         check("no extra output", out_valid, 0);
      end
   endtask

   initial begin
      vecs[0] = '{8'd128, 8'd128, 8'd128, 17'd257,   17'd257,   17'd257,   16'd31251};
      vecs[1] = '{8'd255, 8'd0,   8'd255, 17'd65536, 17'd65536, 17'd65536, 16'd0};
      vecs[2] = '{8'd255, 8'd255, 8'd255, 17'd65536, 17'd65536, 17'd65536, 16'd62258};
      vecs[3] = '{8'd200, 8'd100, 8'd50,  17'd257,   17'd257,   17'd257,   16'd12207};
      vecs[4] = '{8'd50,  8'd200, 8'd100, 17'd257,   17'd257,   17'd257,   16'd12207};
      vecs[5] = '{8'd100, 8'd50,  8'd200, 17'd257,   17'd257,   17'd257,   16'd12207};
      vecs[6] = '{8'd100, 8'd100, 8'd100, 17'd514,   17'd514,   17'd514,   16'd48829};
      vecs[7] = '{8'd128, 8'd128, 8'd128, 17'd257,   17'd0,     17'd257,   16'd0};
      vecs[8] = '{8'd1,   8'd1,   8'd3,   17'd65536, 17'd32768, 17'd16384, 16'd31129};
      vecs[9] = '{8'd0,   8'd0,   8'd0,   17'd257,   17'd257,   17'd257,   16'd0};

      rst_n = 1'b0; a_load = 1'b0; inv_r = '0; inv_g = '0; inv_b = '0;
      in_valid = 1'b0; in_r = '0; in_g = '0; in_b = '0; out_ready = 1'b1;

      repeat (2) @(negedge clk);
      #1;
      check("reset in_ready", in_ready, 0);
      check("reset out_valid", out_valid, 0);
      check("reset out_data", out_data, 0);
      check("reset busy_load", busy_load, 1);
      rst_n = 1'b1;

      // Pixels offered before the first load must be ignored.
      in_valid = 1'b1; in_r = 8'd90; in_g = 8'd90; in_b = 8'd90;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         check("wait_a in_ready", in_ready, 0);
         check("wait_a out_valid", out_valid, 0);
      end
      in_valid = 1'b0;

      for (int i = 0; i < 10; i++) begin
         load_inv(vecs[i].ir, vecs[i].ig, vecs[i].ib);
         run_one(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // 16-pixel stream under a 1,0,0,1 out_ready pattern.
      load_inv(17'd257, 17'd257, 17'd257);
      for (int i = 0; i < 16; i++) begin
         px_r[i] = 8'(i * 13 + 5);
         px_g[i] = 8'(i * 7 + 20);
         px_b[i] = 8'(255 - i * 11);
         px_exp[i] = exp_uniform(px_r[i], px_g[i], px_b[i], 257);
      end
      run_stream(16, 1'b1, -1, 17'd0);

      // Reload 257 -> 514 mid-stream; pixels 0..3 were accepted under 257.
      for (int i = 0; i < 8; i++) begin
         px_r[i] = 8'd100; px_g[i] = 8'd100; px_b[i] = 8'd100;
         px_exp[i] = (i <= 3) ? 16'd24414 : 16'd48829;
      end
      run_stream(8, 1'b0, 3, 17'd514);

      // Reset with the pipe full and stalled.
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; in_r = 8'd128; in_g = 8'd128; in_b = 8'd128;
      repeat (6) @(negedge clk);
      #1;
      check("pre-reset out_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("mid reset out_valid", out_valid, 0);
      check("mid reset out_data", out_data, 0);
      check("mid reset busy_load", busy_load, 1);
      check("mid reset in_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         check("post reset in_ready", in_ready, 0);
         check("post reset out_valid", out_valid, 0);
      end
      in_valid = 1'b0;
      load_inv(17'd257, 17'd257, 17'd257);
      run_one(8'd128, 8'd128, 8'd128, 16'd31251, "after reload");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
